// File: rtl/display_timing_gen.sv
// Raster timing generator: walks the display raster one position per advancing
// edge and presents coordinates, syncs, data-enable and line/frame strobes,
// all registered together so every output describes the same position.
module display_timing_gen #(
  parameter int H_ACTIVE   = 800,
  parameter int H_FP       = 40,
  parameter int H_SYNC     = 128,
  parameter int H_BP       = 88,
  parameter int V_ACTIVE   = 600,
  parameter int V_FP       = 1,
  parameter int V_SYNC     = 4,
  parameter int V_BP       = 23,
  parameter bit H_SYNC_POL = 1'b1,
  parameter bit V_SYNC_POL = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_pix_en,
  output logic [15:0] o_x,
  output logic [15:0] o_y,
  output logic        o_h_sync,
  output logic        o_v_sync,
  output logic        o_de,
  output logic        o_line_start,
  output logic        o_frame_start,
  output logic        o_frame_end
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [15:0] H_LAST     = 16'(H_TOTAL - 1);
  localparam logic [15:0] V_LAST     = 16'(V_TOTAL - 1);
  localparam logic [15:0] H_ACT      = 16'(H_ACTIVE);
  localparam logic [15:0] V_ACT      = 16'(V_ACTIVE);
  localparam logic [15:0] HS_START   = 16'(H_ACTIVE + H_FP);
  localparam logic [15:0] HS_END     = 16'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [15:0] VS_START   = 16'(V_ACTIVE + V_FP);
  localparam logic [15:0] VS_END     = 16'(V_ACTIVE + V_FP + V_SYNC);

  // running_reg is clear after reset: the first advancing edge then lands on
  // (0,0) instead of stepping past it.
  logic        running_reg;
  logic [15:0] x_reg, y_reg;
  logic        h_sync_reg, v_sync_reg, de_reg;
  logic        line_start_reg, frame_start_reg, frame_end_reg;

  logic [15:0] x_next, y_next;
  logic        h_sync_next, v_sync_next, de_next;
  logic        line_start_next, frame_start_next, frame_end_next;

  // Next raster position taken on an advancing edge.
  always_comb begin
    x_next = 16'd0;
    y_next = 16'd0;
    if (running_reg) begin
      if (x_reg == H_LAST) begin
        x_next = 16'd0;
        y_next = (y_reg == V_LAST) ? 16'd0 : y_reg + 16'd1;
      end else begin
        x_next = x_reg + 16'd1;
        y_next = y_reg;
      end
    end
  end

  // Decode of the next position, so decodes are registered alongside it.
  always_comb begin
    de_next          = (x_next < H_ACT) && (y_next < V_ACT);
    h_sync_next      = ((x_next >= HS_START) && (x_next < HS_END)) ? H_SYNC_POL : ~H_SYNC_POL;
    v_sync_next      = ((y_next >= VS_START) && (y_next < VS_END)) ? V_SYNC_POL : ~V_SYNC_POL;
    line_start_next  = (x_next == 16'd0);
    frame_start_next = line_start_next && (y_next == 16'd0);
    frame_end_next   = line_start_next && (y_next == V_ACT);
  end

  // Position/decode registers; strobes only survive the cycle after an advance.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      running_reg     <= 1'b0;
      x_reg           <= 16'd0;
      y_reg           <= 16'd0;
      h_sync_reg      <= ~H_SYNC_POL;
      v_sync_reg      <= ~V_SYNC_POL;
      de_reg          <= 1'b0;
      line_start_reg  <= 1'b0;
      frame_start_reg <= 1'b0;
      frame_end_reg   <= 1'b0;
    end else if (i_pix_en) begin
      running_reg     <= 1'b1;
      x_reg           <= x_next;
      y_reg           <= y_next;
      h_sync_reg      <= h_sync_next;
      v_sync_reg      <= v_sync_next;
      de_reg          <= de_next;
      line_start_reg  <= line_start_next;
      frame_start_reg <= frame_start_next;
      frame_end_reg   <= frame_end_next;
    end else begin
      line_start_reg  <= 1'b0;
      frame_start_reg <= 1'b0;
      frame_end_reg   <= 1'b0;
    end
  end

  assign o_x           = x_reg;
  assign o_y           = y_reg;
  assign o_h_sync      = h_sync_reg;
  assign o_v_sync      = v_sync_reg;
  assign o_de          = de_reg;
  assign o_line_start  = line_start_reg;
  assign o_frame_start = frame_start_reg;
  assign o_frame_end   = frame_end_reg;

endmodule
